// File: rtl/shiftrow_elastic.sv
// ShiftRows/InvShiftRows stage with a 2-entry elastic output buffer.
// Optional tag sideband enabled by defining SHIFTROW_ELASTIC_TAG_EN.
module shiftrow_elastic #(
  parameter int unsigned NB = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [0:32*NB-1]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:32*NB-1]  out_data,
`ifdef SHIFTROW_ELASTIC_TAG_EN
  input  logic [3:0]        in_tag,
  output logic [3:0]        out_tag,
`endif
  output logic [1:0]        occupancy
);

  localparam int unsigned W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 7 || NB == 8)) begin : g_bad_nb
    $error("shiftrow_elastic: NB must be 4, 6, 7 or 8");
  end

  function automatic int unsigned row_off(input int unsigned r);
    if (r == 0) return 0;
    if (r == 1) return 1;
    if (r == 2) return (NB == 8) ? 3 : 2;
    return (NB == 4 || NB == 6) ? 3 : 4;
  endfunction

  logic [0:W-1] perm_data;

  // Both source columns are elaboration-time constants, so this is a 2:1 mux per byte.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int unsigned FwdSrc = (c + row_off(r)) % NB;
      localparam int unsigned InvSrc = (c + NB - row_off(r)) % NB;
      assign perm_data[8*(4*c+r) +: 8] = in_inv ? in_data[8*(4*InvSrc+r) +: 8]
                                                : in_data[8*(4*FwdSrc+r) +: 8];
    end
  end

  logic [0:W-1] slot0_q, slot1_q;
  logic [1:0]   count_q;
  logic         push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign occupancy = count_q;
  assign out_data  = slot0_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // slot0 is always the head; it is left untouched when the last entry pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      if (pop && count_q == 2'd2) slot0_q <= slot1_q;
      if (push) begin
        if (count_q == 2'd0 || (count_q == 2'd1 && pop)) slot0_q <= perm_data;
        else slot1_q <= perm_data;
      end
      if (push && !pop) count_q <= count_q + 2'd1;
      else if (pop && !push) count_q <= count_q - 2'd1;
    end
  end

`ifdef SHIFTROW_ELASTIC_TAG_EN
  logic [3:0] tag0_q, tag1_q;

  assign out_tag = tag0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag0_q <= 4'd0;
      tag1_q <= 4'd0;
    end else if (!flush) begin
      if (pop && count_q == 2'd2) tag0_q <= tag1_q;
      if (push) begin
        if (count_q == 2'd0 || (count_q == 2'd1 && pop)) tag0_q <= in_tag;
        else tag1_q <= in_tag;
      end
    end
  end
`endif

endmodule

// File: tb/tb_shiftrow_elastic.sv
// Self-checking bench for shiftrow_elastic: NB=4 and NB=8 instances against a byte-matrix model.
module tb_shiftrow_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;
  logic v4, r4, inv4, ov4, ordy4;
  logic [0:127] d4, o4;
  logic [1:0] occ4;
  logic v8, r8, inv8, ov8, ordy8;
  logic [0:255] d8, o8;
  logic [1:0] occ8;
`ifdef SHIFTROW_ELASTIC_TAG_EN
  logic [3:0] tin4, tout4, tin8, tout8;
  assign tin4 = 4'd0;
  assign tin8 = 4'd0;
`endif

  int checks = 0;
  int failures = 0;

  shiftrow_elastic #(.NB(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v4), .in_ready(r4), .in_inv(inv4),
    .in_data(d4), .out_valid(ov4), .out_ready(ordy4), .out_data(o4),
`ifdef SHIFTROW_ELASTIC_TAG_EN
    .in_tag(tin4), .out_tag(tout4),
`endif
    .occupancy(occ4)
  );

  shiftrow_elastic #(.NB(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v8), .in_ready(r8), .in_inv(inv8),
    .in_data(d8), .out_valid(ov8), .out_ready(ordy8), .out_data(o8),
`ifdef SHIFTROW_ELASTIC_TAG_EN
    .in_tag(tin8), .out_tag(tout8),
`endif
    .occupancy(occ8)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: unpack into a 4 x nb byte matrix and rotate each row by its offset.
  function automatic logic [0:255] ref_perm(input logic [0:255] d, input int nb, input bit inv);
    logic [7:0] st[4][8];
    int off[4];
    logic [0:255] res;
    off[0] = 0;
    off[1] = 1;
    off[2] = (nb == 8) ? 3 : 2;
    off[3] = (nb == 7 || nb == 8) ? 4 : 3;
    res = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) st[r][c] = d[8*(4*c+r) +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) begin
        if (!inv) res[8*(4*c+r) +: 8] = st[r][(c + off[r]) % nb];
        else      res[8*(4*((c + off[r]) % nb)+r) +: 8] = st[r][c];
      end
    return res;
  endfunction

  function automatic logic [0:127] perm4(input logic [0:127] d, input bit inv);
    logic [0:255] t;
    t = ref_perm({d, 128'h0}, 4, inv);
    return t[0:127];
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [0:255] rand256();
    return {rand128(), rand128()};
  endfunction

  logic [0:127] s, y, exp4;
  logic [0:127] xs[11];
  logic [0:127] q[$];
  logic [0:255] s8;
  bit do_push, do_pop;

  initial begin
    rst = 1'b1; flush = 1'b0;
    v4 = 1'b0; inv4 = 1'b0; d4 = '0; ordy4 = 1'b0;
    v8 = 1'b0; inv8 = 1'b0; d8 = '0; ordy8 = 1'b1;
    step();
    chk("rst_occ4", occ4, 0);
    chk("rst_ov4", ov4, 0);
    chk("rst_ir4", r4, 1);
    chk("rst_od4", o4, 0);
    chk("rst_occ8", occ8, 0);
    chk("rst_od8", o8, 0);
`ifdef SHIFTROW_ELASTIC_TAG_EN
    chk("rst_tag4", tout4, 0);
`endif
    rst = 1'b0;

    // Known forward vector, single-cycle output pulse, then hold while empty.
    v4 = 1'b1; inv4 = 1'b0; ordy4 = 1'b1;
    d4 = 128'h000102030405060708090a0b0c0d0e0f;
    step();
    chk("fwd4_ov", ov4, 1);
    chk("fwd4_data", o4, 128'h00050a0f04090e03080d02070c01060b);
    v4 = 1'b0;
    step();
    chk("fwd4_ov_drop", ov4, 0);
    chk("fwd4_hold", o4, 128'h00050a0f04090e03080d02070c01060b);

    v4 = 1'b1; inv4 = 1'b1;
    d4 = 128'h00050a0f04090e03080d02070c01060b;
    step();
    chk("inv4_data", o4, 128'h000102030405060708090a0b0c0d0e0f);
    v4 = 1'b0;
    step();

    // NB=8 known vector.
    for (int k = 0; k < 32; k++) d8[8*k +: 8] = 8'(k);
    v8 = 1'b1; inv8 = 1'b0;
    step();
    chk("nb8_b0", o8[0:7], 8'h00);
    chk("nb8_b1", o8[8:15], 8'h05);
    chk("nb8_b2", o8[16:23], 8'h0e);
    chk("nb8_b3", o8[24:31], 8'h13);
    chk("nb8_full", o8, ref_perm(d8, 8, 1'b0));
    v8 = 1'b0;
    step();

    // Random round trips with alternating direction, streaming at full rate.
    ordy4 = 1'b1; ordy8 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s = rand128();
      s8 = rand256();
      v4 = 1'b1; inv4 = 1'b0; d4 = s;
      v8 = 1'b1; inv8 = i[0]; d8 = s8;
      step();
      y = o4;
      chk("rt_fwd", y, perm4(s, 1'b0));
      chk("rnd_nb8", o8, ref_perm(s8, 8, i[0]));
      inv4 = 1'b1; d4 = y;
      v8 = 1'b0;
      step();
      chk("rt_back", o4, s);
    end
    v4 = 1'b0; v8 = 1'b0;
    step();
    chk("rt_empty", occ4, 0);

    // Backpressure: three pushes into a stalled buffer.
    ordy4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      xs[k] = rand128();
      v4 = 1'b1; inv4 = k[0]; d4 = xs[k];
      xs[k] = perm4(xs[k], k[0]);
      step();
    end
    chk("bp_occ", occ4, 2);
    chk("bp_ir", r4, 0);
    chk("bp_head", o4, xs[0]);
    v4 = 1'b0;
    step();
    chk("bp_stable", o4, xs[0]);
    chk("bp_ov", ov4, 1);
    ordy4 = 1'b1;
    step();
    chk("bp_second", o4, xs[1]);
    chk("bp_occ1", occ4, 1);
    step();
    chk("bp_drained", ov4, 0);
    chk("bp_occ0", occ4, 0);

    // Simultaneous push and pop at occupancy 1.
    ordy4 = 1'b0; v4 = 1'b1; inv4 = 1'b0;
    s = rand128(); d4 = s; xs[0] = perm4(s, 1'b0);
    step();
    chk("pp_occ_start", occ4, 1);
    ordy4 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      s = rand128(); inv4 = i[0]; d4 = s; xs[i] = perm4(s, i[0]);
      chk("pp_head_pre", o4, xs[i-1]);
      step();
      chk("pp_occ", occ4, 1);
    end
    v4 = 1'b0;
    chk("pp_last", o4, xs[10]);
    step();
    chk("pp_drain", occ4, 0);

    // Random handshake traffic against a queue scoreboard.
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      v4 = ($urandom() % 2) != 0;
      ordy4 = ($urandom() % 4) != 0;
      inv4 = ($urandom() % 2) != 0;
      d4 = rand128();
      do_push = v4 && (q.size() < 2);
      do_pop = (q.size() > 0) && ordy4;
      step();
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(perm4(d4, inv4));
      chk("sb_occ", occ4, 256'(q.size()));
      chk("sb_ov", ov4, q.size() != 0);
      chk("sb_ir", r4, q.size() != 2);
      if (q.size() != 0) chk("sb_data", o4, q[0]);
    end
    v4 = 1'b0; ordy4 = 1'b1;
    step(); step();
    chk("sb_drain", occ4, 0);

    // Flush while full with a push and pop offered in the same cycle.
    ordy4 = 1'b0; v4 = 1'b1;
    d4 = rand128(); step();
    d4 = rand128(); step();
    chk("fl_full", occ4, 2);
    flush = 1'b1; ordy4 = 1'b1; d4 = rand128();
    step();
    chk("fl_occ", occ4, 0);
    chk("fl_ov", ov4, 0);
    chk("fl_ir", r4, 1);
    flush = 1'b0; v4 = 1'b0;
    step();
    chk("fl_no_emit", ov4, 0);

    // Reset in the middle of traffic.
    ordy4 = 1'b0; v4 = 1'b1; d4 = rand128();
    v8 = 1'b1; ordy8 = 1'b0; d8 = rand256();
    step();
    chk("mid_occ", occ4, 1);
    rst = 1'b1;
    step();
    chk("mrst_occ4", occ4, 0);
    chk("mrst_ov4", ov4, 0);
    chk("mrst_ir4", r4, 1);
    chk("mrst_od4", o4, 0);
    chk("mrst_occ8", occ8, 0);
    chk("mrst_od8", o8, 0);
    rst = 1'b0; v4 = 1'b0; v8 = 1'b0; ordy4 = 1'b1;
    step();
    chk("mrst_no_emit", ov4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
